// File: rtl/parity_frame_pkg.sv
// Shared state encoding and frame-format constants for the parity frame link.
package parity_frame_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_PAR  = 2'd2,
        S_STOP = 2'd3
    } state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/reduce_flags.sv
// Combinational parity check and reduction flags on a received word.
module reduce_flags #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic [WIDTH-1:0] word_i,
    input  logic             p_i,
    output logic             par_bad_o,
    output logic             zero_o,
    output logic             ones_o
);

    // The parity bit matches when (^word ^ p) equals the selected parity sense.
    always_comb begin
        par_bad_o = (^word_i) ^ p_i ^ PARITY_ODD;
        zero_o    = ~|word_i;
        ones_o    = &word_i;
    end

endmodule

// File: rtl/parity_frame_rx.sv
// Serial parity frame receiver: start, WIDTH data bits LSB-first, parity, stop.
module parity_frame_rx
    import parity_frame_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_en,
    input  logic             rx_bit,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             parity_err,
    output logic             frame_err,
    output logic             zero_flag,
    output logic             ones_flag,
    output logic             busy
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic               p_q, p_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               valid_q, valid_d;
    logic               perr_q, perr_d;
    logic               ferr_q, ferr_d;
    logic               zero_q, zero_d;
    logic               ones_q, ones_d;
    logic               busy_q, busy_d;

    logic               par_bad_c;
    logic               zero_c;
    logic               ones_c;

    reduce_flags #(
        .WIDTH      (WIDTH),
        .PARITY_ODD (PARITY_ODD)
    ) u_reduce_flags (
        .word_i    (sr_q),
        .p_i       (p_q),
        .par_bad_o (par_bad_c),
        .zero_o    (zero_c),
        .ones_o    (ones_c)
    );

    // Next-state, datapath and commit logic; everything advances only on rx_en.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        p_d     = p_q;
        data_d  = data_q;
        valid_d = 1'b0;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        zero_d  = zero_q;
        ones_d  = ones_q;

        if (rx_en) begin
            case (state_q)
                S_IDLE: begin
                    if (rx_bit == START_BIT) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                    end
                end
                S_DATA: begin
                    sr_d = {rx_bit, sr_q[WIDTH-1:1]};
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_PAR;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_PAR: begin
                    p_d     = rx_bit;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    data_d  = sr_q;
                    valid_d = 1'b1;
                    perr_d  = par_bad_c;
                    ferr_d  = (rx_bit != STOP_BIT);
                    zero_d  = zero_c;
                    ones_d  = ones_c;
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Busy also covers the commit cycle after the stop strobe.
        busy_d = (state_d != S_IDLE) || valid_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            p_q     <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            zero_q  <= 1'b1;
            ones_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            p_q     <= p_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            zero_q  <= zero_d;
            ones_q  <= ones_d;
            busy_q  <= busy_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign zero_flag  = zero_q;
    assign ones_flag  = ones_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_parity_frame_rx.sv
// Bench for parity_frame_rx: even- and odd-parity instances on one serial line.
module tb_parity_frame_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_en;
    logic       rx_bit;

    logic [7:0] do_e, do_o;
    logic       v_e, pe_e, fe_e, z_e, o_e, b_e;
    logic       v_o, pe_o, fe_o, z_o, o_o, b_o;

    always #5 clk = ~clk;

    parity_frame_rx #(.WIDTH(8), .PARITY_ODD(1'b0)) dut_e (
        .clk        (clk),
        .rst        (rst),
        .rx_en      (rx_en),
        .rx_bit     (rx_bit),
        .data_out   (do_e),
        .data_valid (v_e),
        .parity_err (pe_e),
        .frame_err  (fe_e),
        .zero_flag  (z_e),
        .ones_flag  (o_e),
        .busy       (b_e)
    );

    parity_frame_rx #(.WIDTH(8), .PARITY_ODD(1'b1)) dut_o (
        .clk        (clk),
        .rst        (rst),
        .rx_en      (rx_en),
        .rx_bit     (rx_bit),
        .data_out   (do_o),
        .data_valid (v_o),
        .parity_err (pe_o),
        .frame_err  (fe_o),
        .zero_flag  (z_o),
        .ones_flag  (o_o),
        .busy       (b_o)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       perr_e;
        logic       perr_o;
        logic       ferr;
        logic       zero;
        logic       ones;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       p;
        logic       stop;
        exp_t       exp;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;
    logic prev_v = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] d, input logic p, input logic stop,
                                input logic pe, input logic po, input logic fe,
                                input logic z, input logic o);
        vec_t v;
        v.data = d;
        v.p    = p;
        v.stop = stop;
        v.exp  = '{data: d, perr_e: pe, perr_o: po, ferr: fe, zero: z, ones: o};
        return v;
    endfunction

    // One strobe: rx_en high across a single posedge, returns mid-cycle after it.
    task automatic strobe(input logic b);
        @(negedge clk);
        rx_en  = 1'b1;
        rx_bit = b;
        @(negedge clk);
        rx_en  = 1'b0;
        rx_bit = 1'b1;
    endtask

    task automatic send_frame(input vec_t v, input int gap_at);
        @(negedge clk);
        check("busy_idle", 16'(b_e), 16'(0));
        check("valid_low_before_start", 16'(v_e), 16'(0));
        rx_en  = 1'b1;
        rx_bit = 1'b0;
        @(negedge clk);
        rx_en  = 1'b0;
        rx_bit = 1'b1;
        check("busy_after_start", 16'(b_e), 16'(1));
        for (int i = 0; i < 8; i++) begin
            if (i == gap_at) begin
                repeat (20) @(negedge clk);
                check("busy_in_gap", 16'(b_e), 16'(1));
                check("valid_in_gap", 16'(v_e), 16'(0));
            end
            strobe(v.data[i]);
        end
        strobe(v.p);
        check("valid_before_stop", 16'(v_e), 16'(0));
        sb_q.push_back(v.exp);
        strobe(v.stop);
        check("valid_latency", 16'(v_e), 16'(1));
        check("busy_after_stop", 16'(b_e), 16'(1));
    endtask

    // Scoreboard: each valid pulse pops one expected frame and compares both instances.
    always @(negedge clk) begin
        if (v_e) begin
            exp_t e;
            check("valid_width", 16'(prev_v), 16'(0));
            check("valid_pair", 16'(v_o), 16'(1));
            check("sb_nonempty", 16'(sb_q.size() != 0), 16'(1));
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("data_e",  16'(do_e), 16'(e.data));
                check("perr_e",  16'(pe_e), 16'(e.perr_e));
                check("ferr_e",  16'(fe_e), 16'(e.ferr));
                check("zero_e",  16'(z_e),  16'(e.zero));
                check("ones_e",  16'(o_e),  16'(e.ones));
                check("data_o",  16'(do_o), 16'(e.data));
                check("perr_o",  16'(pe_o), 16'(e.perr_o));
                check("ferr_o",  16'(fe_o), 16'(e.ferr));
                check("zero_o",  16'(z_o),  16'(e.zero));
                check("ones_o",  16'(o_o),  16'(e.ones));
            end
        end
        prev_v <= v_e;
    end

    task automatic check_reset_values();
        check("reset_e", 16'({do_e, v_e, pe_e, fe_e, z_e, o_e, b_e}), 16'({8'h00, 6'b000100}));
        check("reset_o", 16'({do_o, v_o, pe_o, fe_o, z_o, o_o, b_o}), 16'({8'h00, 6'b000100}));
    endtask

    initial begin
        //            data   p     stop  pe_e  pe_o  ferr  zero  ones
        vecs[0] = mk(8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[1] = mk(8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        vecs[2] = mk(8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        vecs[3] = mk(8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[4] = mk(8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[5] = mk(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        rst    = 1'b1;
        rx_en  = 1'b0;
        rx_bit = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values();
        rst = 1'b0;

        for (int k = 0; k < 6; k++) begin
            send_frame(vecs[k], -1);
        end

        // Abort a frame after four data bits; reset wins over a coincident start strobe.
        strobe(1'b0);
        strobe(1'b1);
        strobe(1'b0);
        strobe(1'b1);
        strobe(1'b1);
        check("busy_mid_frame", 16'(b_e), 16'(1));
        @(negedge clk);
        rst    = 1'b1;
        rx_en  = 1'b1;
        rx_bit = 1'b0;
        @(negedge clk);
        check_reset_values();
        rst    = 1'b0;
        rx_en  = 1'b0;
        rx_bit = 1'b1;

        send_frame(mk(8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), -1);

        // Odd-parity frame with a 20-clock rx_en gap after four data bits.
        send_frame(mk(8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 4);

        repeat (4) @(negedge clk);
        check("sb_drained", 16'(sb_q.size()), 16'(0));
        check("idle_at_end", 16'({v_e, b_e, v_o, b_o}), 16'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
